l3_cache: RTL and testbench
===========================

# l3_cache

Direct-mapped, write-through, no-write-allocate last-level cache that sits directly downstream of the L2 cache and upstream of main memory. It accepts one L2 request at a time on the L3_* port and returns a full 1024-bit line on L2_block; the L2 splits that line into its two 512-bit halves. Misses and all writes are forwarded to main memory over a ready-terminated mem_* port.

## Interface
- INDEX_BITS, 10: line index width; the cache holds 2^INDEX_BITS lines of 128 bytes each.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- L3_addr  in  32  byte address from L2. Index = addr[INDEX_BITS+6:7], tag = addr[31:INDEX_BITS+7], word = addr[6:2].
- L3_wdata  in  32  write word.
- L3_wenable  in  1  1 = write request, 0 = read request; qualified by L3_renable.
- L3_renable  in  1  request valid; held high by L2 until the request completes.
- L3_stall  out  1  1 = request in progress; 0 with a request pending = response complete.
- L2_block  out  [0:1023]  line returned to L2. Bit 0 is the MSB; word w occupies bits [w*32 +: 32].
- mem_addr  out  32  line-aligned address for reads (addr[6:0]=0); full byte address for writes.
- mem_renable  out  1  line-read request.
- mem_wenable  out  1  word-write request.
- mem_wdata  out  32  write word.
- mem_ready  in  1  one-cycle completion pulse from memory.
- mem_block  in  [0:1023]  read line; valid in the cycle mem_ready is high.

## Operation
- Storage: per line, a valid bit, a tag of 32-INDEX_BITS-7 bits, and 1024 data bits.
- FSM states: IDLE, LOOKUP, MEM_RD, MEM_WR, DONE.
- IDLE:
  - When L3_renable=1, capture L3_addr, L3_wdata and L3_wenable into request registers and go to LOOKUP.
  - Inputs are ignored after capture.
- LOOKUP: hit = valid[idx] && tag match.
  - Read hit: L2_block <= line; go to DONE.
  - Read miss: go to MEM_RD.
  - Write, hit or miss: if hit, merge wdata into the line at word addr[6:2]; go to MEM_WR. A write miss never allocates.
- MEM_RD:
  - Drive mem_renable=1 and the line-aligned mem_addr until mem_ready.
  - On mem_ready, in one cycle: line <= mem_block, tag <= req tag, valid <= 1, L2_block <= mem_block; go to DONE.
  - The fill overwrites any resident line at that index. Nothing is dirty, so no writeback is needed.
- MEM_WR:
  - Drive mem_wenable=1, mem_addr=req addr and mem_wdata=req wdata until mem_ready; then go to DONE.
  - L2_block is left unchanged on writes.
- DONE:
  - L3_stall=0.
  - Return to IDLE once L3_renable=0.
  - L2 must drop L3_renable for at least one cycle between requests. A request held high in DONE is not re-executed.
- mem_ready outside MEM_RD/MEM_WR is ignored.

## Timing
- Reset, asynchronous:
  - state=IDLE, all valid bits=0.
  - L3_stall=0, L2_block=0, mem_renable=0, mem_wenable=0, mem_addr=0, mem_wdata=0.
  - Data and tag arrays are not reset.
- L3_stall = (state∈{LOOKUP,MEM_RD,MEM_WR}) || (state==IDLE && L3_renable). It is combinational, so stall rises in the same cycle the request appears.
- Read-hit latency: request seen in IDLE at edge 0; LOOKUP at edge 1; DONE with L2_block valid after edge 2 (2 cycles).
- Miss and write latency: 2 cycles plus memory wait; DONE is entered on the edge that samples mem_ready.
- mem_renable and mem_wenable are registered. They rise on the edge entering MEM_RD/MEM_WR and fall on the edge that samples mem_ready. They are never both high.
- Reset mid-miss or mid-write:
  - The request is abandoned and mem_* drop immediately.
  - No line is filled.
  - A later mem_ready is ignored.
- Line replacement on a tag conflict is the only eviction; the index wraps across the whole address space.

## Test plan
- Cold read:
  - Stimulus: after reset, read 0x0000_0080; memory answers after 5 cycles with block word0=0xA5A5_0000…word31=0xA5A5_001F.
  - Required: L3_stall=1 for 7 cycles, then 0. L2_block matches mem_block. mem_addr=0x0000_0080, one mem_renable pulse train.
- Read hit: re-read 0x0000_0084 -> L3_stall high exactly 2 cycles, no mem_renable, L2_block unchanged from the fill.
- Write hit:
  - Stimulus: write 0xDEADBEEF to 0x0000_0088, then read 0x0000_0080.
  - Required: mem_wenable with mem_addr=0x0000_0088, mem_wdata=0xDEADBEEF. Next read hits, with bits [64:95]=0xDEADBEEF.
- Write miss: write to 0x0001_0000 -> memory write issued. A following read of 0x0001_0000 misses, showing no allocation.
- Conflict: read 0x0000_0080, then 0x0002_0080 (same index, INDEX_BITS=10), then 0x0000_0080 -> three misses and three mem reads.
- Reset mid-miss:
  - Stimulus: assert rst_n=0 while in MEM_RD, release, pulse mem_ready, then read the same address.
  - Required: mem_renable drops asynchronously, the stray ready is ignored, and the read misses again.

Source files
------------

// File: rtl/l3_cache_if.sv
// L2-facing request/response bus plus the memory-facing line port of the L3.
interface l3_cache_if;
  logic [31:0]   L3_addr;
  logic [31:0]   L3_wdata;
  logic          L3_wenable;
  logic          L3_renable;
  logic          L3_stall;
  logic [0:1023] L2_block;
  logic [31:0]   mem_addr;
  logic          mem_renable;
  logic          mem_wenable;
  logic [31:0]   mem_wdata;
  logic          mem_ready;
  logic [0:1023] mem_block;

  modport slave (
    input  L3_addr, L3_wdata, L3_wenable, L3_renable, mem_ready, mem_block,
    output L3_stall, L2_block, mem_addr, mem_renable, mem_wenable, mem_wdata
  );

  modport master (
    output L3_addr, L3_wdata, L3_wenable, L3_renable, mem_ready, mem_block,
    input  L3_stall, L2_block, mem_addr, mem_renable, mem_wenable, mem_wdata
  );
endinterface

// File: rtl/l3_cache.sv
// Direct-mapped, write-through, no-write-allocate L3 with 128-byte lines.
// One request in flight; misses and every write go to memory.
module l3_cache #(
  parameter int INDEX_BITS = 10
) (
  input logic      clk,
  input logic      rst_n,
  l3_cache_if.slave bus
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 32 - INDEX_BITS - 7;

  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, MEM_WR, DONE} state_t;

  state_t state, state_nxt;

  logic [31:0] req_addr, req_wdata;
  logic        req_we;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [0:1023]    data_mem [LINES];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      req_tag;
  logic [4:0]            word;
  logic                  hit;

  assign idx     = req_addr[INDEX_BITS+6:7];
  assign req_tag = req_addr[31:INDEX_BITS+7];
  assign word    = req_addr[6:2];
  assign hit     = valid[idx] && (tag_mem[idx] == req_tag);

  // Stall is combinational so L2 sees it in the same cycle it raises the request.
  assign bus.L3_stall = (state == LOOKUP) || (state == MEM_RD) || (state == MEM_WR) ||
                        ((state == IDLE) && bus.L3_renable);

  // State register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  // Next-state logic; DONE waits for L2 to drop the request so it is never replayed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.L3_renable) state_nxt = LOOKUP;
      LOOKUP:  if (req_we)         state_nxt = MEM_WR;
               else if (hit)       state_nxt = DONE;
               else                state_nxt = MEM_RD;
      MEM_RD:  if (bus.mem_ready)  state_nxt = DONE;
      MEM_WR:  if (bus.mem_ready)  state_nxt = DONE;
      DONE:    if (!bus.L3_renable) state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Capture the request once; inputs are ignored until the next IDLE.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      req_addr  <= '0;
      req_wdata <= '0;
      req_we    <= 1'b0;
    end else if (state == IDLE && bus.L3_renable) begin
      req_addr  <= bus.L3_addr;
      req_wdata <= bus.L3_wdata;
      req_we    <= bus.L3_wenable;
    end

  // Valid bits: set on fill, cleared only by reset (nothing is ever invalidated).
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                              valid      <= '0;
    else if (state == MEM_RD && bus.mem_ready) valid[idx] <= 1'b1;

  // Tag/data arrays: write-hit merge and line fill; deliberately not reset.
  always_ff @(posedge clk) begin
    if (state == LOOKUP && req_we && hit)
      data_mem[idx][word*32 +: 32] <= req_wdata;
    if (state == MEM_RD && bus.mem_ready) begin
      data_mem[idx] <= bus.mem_block;
      tag_mem[idx]  <= req_tag;
    end
  end

  // Registered memory-port and L2 response outputs; enables follow next state.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.mem_renable <= 1'b0;
      bus.mem_wenable <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.L2_block    <= '0;
    end else begin
      bus.mem_renable <= (state_nxt == MEM_RD);
      bus.mem_wenable <= (state_nxt == MEM_WR);
      if (state == LOOKUP) begin
        if (req_we) begin
          bus.mem_addr  <= req_addr;
          bus.mem_wdata <= req_wdata;
        end else if (!hit) begin
          bus.mem_addr  <= {req_addr[31:7], 7'b0};
        end else begin
          bus.L2_block  <= data_mem[idx];
        end
      end
      if (state == MEM_RD && bus.mem_ready)
        bus.L2_block <= bus.mem_block;
    end
endmodule

// File: tb/tb_l3_cache.sv
// Scoreboard bench for l3_cache: behavioural cache + memory model predicts
// stall length, memory traffic and the returned line for every request.
module tb_l3_cache;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  l3_cache_if bus ();

  l3_cache #(.INDEX_BITS(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    int            stall;
    int            rd;
    int            wr;
    logic [0:1023] blk;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: memory word overrides, resident line per index, cached data.
  logic [31:0]   mem_w   [logic [31:0]];
  logic [31:0]   line_of [int];
  logic [0:1023] md      [int];
  logic [0:1023] exp_l2  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:1023] mem_line(input logic [31:0] a);
    logic [0:1023] b;
    logic [31:0]   la, wa;
    la = {a[31:7], 7'b0};
    for (int w = 0; w < 32; w++) begin
      wa = la + 32'(w * 4);
      if (mem_w.exists(wa)) b[w*32 +: 32] = mem_w[wa];
      else b[w*32 +: 32] = 32'hA5A5_0000 + 32'(w) + (((la >> 7) - 32'd1) << 8);
    end
    return b;
  endfunction

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int lat);
    exp_t          e;
    int            idx, n, rd, wr, wcnt;
    logic          hit, prev_r, prev_w, done;
    logic [31:0]   la;
    logic [0:1023] t;
    logic [31:0]   wo;
    idx = int'(addr[16:7]);
    la  = {addr[31:7], 7'b0};
    hit = line_of.exists(idx) && (line_of[idx] == la);
    e.rd = 0; e.wr = 0;
    if (we) begin
      e.stall = 2 + lat; e.wr = 1; e.blk = exp_l2;
      mem_w[{addr[31:2], 2'b0}] = wdata;
      if (hit) begin
        t = md[idx]; t[int'(addr[6:2])*32 +: 32] = wdata; md[idx] = t;
      end
    end else if (hit) begin
      e.stall = 2; e.blk = md[idx];
    end else begin
      e.stall = 2 + lat; e.rd = 1; e.blk = mem_line(addr);
      line_of[idx] = la; md[idx] = e.blk;
    end
    if (!we) exp_l2 = e.blk;
    sb.push_back(e);

    @(negedge clk);
    bus.L3_addr = addr; bus.L3_wdata = wdata; bus.L3_wenable = we; bus.L3_renable = 1'b1;
    bus.mem_block = mem_line(addr); bus.mem_ready = 1'b0;
    n = 0; rd = 0; wr = 0; wcnt = 0; prev_r = 0; prev_w = 0; done = 0;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (!bus.L3_stall) begin done = 1; break; end
      n++;
      if (bus.mem_renable && !prev_r) rd++;
      if (bus.mem_wenable && !prev_w) wr++;
      prev_r = bus.mem_renable; prev_w = bus.mem_wenable;
      if (bus.mem_renable && bus.mem_wenable) chk("both_en", 32'd1, 32'd0);
      if (bus.mem_renable) chk("rd_addr", bus.mem_addr, la);
      if (bus.mem_wenable) begin
        chk("wr_addr", bus.mem_addr, addr);
        chk("wr_data", bus.mem_wdata, wdata);
      end
      if (bus.mem_renable || bus.mem_wenable) begin
        wcnt++;
        if (wcnt == lat) bus.mem_ready = 1'b1;
      end
      @(negedge clk);
      bus.mem_ready = 1'b0;
    end
    if (!done) chk("timeout", 32'd1, 32'd0);

    e = sb.pop_front();
    chk("stall_cycles", 32'(n), 32'(e.stall));
    chk("mem_reads", 32'(rd), 32'(e.rd));
    chk("mem_writes", 32'(wr), 32'(e.wr));
    for (int w = 0; w < 32; w++) begin
      wo = bus.L2_block[w*32 +: 32];
      chk("l2_word", wo, e.blk[w*32 +: 32]);
    end
    // Request held high in DONE must not be replayed.
    repeat (2) begin
      @(negedge clk); #1;
      chk("done_hold", {29'd0, bus.L3_stall, bus.mem_renable, bus.mem_wenable}, 32'd0);
    end
    @(negedge clk);
    bus.L3_renable = 1'b0;
    @(negedge clk); #1;
    chk("idle_stall", {31'd0, bus.L3_stall}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_stall"}, {31'd0, bus.L3_stall}, 32'd0);
    chk({tag, "_en"}, {30'd0, bus.mem_renable, bus.mem_wenable}, 32'd0);
    chk({tag, "_addr"}, bus.mem_addr, 32'd0);
    chk({tag, "_wdata"}, bus.mem_wdata, 32'd0);
    chk({tag, "_blk"}, {31'd0, |bus.L2_block}, 32'd0);
  endtask

  initial begin
    logic [31:0] wo;
    logic [31:0] pool [6];
    bus.L3_addr = '0; bus.L3_wdata = '0; bus.L3_wenable = 1'b0; bus.L3_renable = 1'b0;
    bus.mem_ready = 1'b0; bus.mem_block = '0;
    pool = '{32'h0000_0080, 32'h0000_0084, 32'h0002_0080, 32'h0000_0100,
             32'h0001_0000, 32'h0004_0100};

    repeat (3) @(negedge clk);
    #1 chk_reset_outputs("reset");
    // Stray ready while idle must be harmless.
    bus.mem_ready = 1'b1;
    @(negedge clk); bus.mem_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk); #1 chk_reset_outputs("post_reset");

    do_req(1'b0, 32'h0000_0080, 32'h0, 5);            // cold read, 7 stall cycles
    do_req(1'b0, 32'h0000_0084, 32'h0, 5);            // hit, 2 cycles
    do_req(1'b1, 32'h0000_0088, 32'hDEAD_BEEF, 3);    // write hit
    do_req(1'b0, 32'h0000_0080, 32'h0, 4);            // hit with merged word
    wo = bus.L2_block[64:95];
    chk("merged_word", wo, 32'hDEAD_BEEF);
    do_req(1'b1, 32'h0001_0000, 32'h1234_5678, 2);    // write miss
    do_req(1'b0, 32'h0001_0000, 32'h0, 2);            // still misses: no allocate
    do_req(1'b0, 32'h0002_0080, 32'h0, 3);            // conflict evicts 0x80
    do_req(1'b0, 32'h0000_0080, 32'h0, 1);            // miss again
    do_req(1'b0, 32'h0002_0080, 32'h0, 6);            // miss again

    // Reset while a miss is outstanding.
    @(negedge clk);
    bus.L3_addr = 32'h0000_0300; bus.L3_wenable = 1'b0; bus.L3_renable = 1'b1;
    bus.mem_block = mem_line(32'h0000_0300);
    repeat (2) @(negedge clk);
    #1 chk("ren_before_rst", {31'd0, bus.mem_renable}, 32'd1);
    #1 rst_n = 1'b0; bus.L3_renable = 1'b0;
    #1 chk_reset_outputs("mid_rst");
    line_of.delete(); md.delete(); exp_l2 = '0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); bus.mem_ready = 1'b1;
    @(negedge clk); bus.mem_ready = 1'b0; #1;
    chk_reset_outputs("stray_ready");
    do_req(1'b0, 32'h0000_0300, 32'h0, 2);            // must miss: nothing was filled
    do_req(1'b0, 32'h0000_0300, 32'h0, 2);            // now hits

    // Mixed traffic over a few colliding lines.
    for (int i = 0; i < 24; i++)
      do_req($urandom_range(0, 2) == 0, pool[$urandom_range(0, 5)], $urandom,
             int'($urandom_range(1, 4)));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
